// File: rtl/spram_port_arbiter.sv
// Two-port round-robin arbiter in front of one initialised single-port RAM.
// Define SPRAM_ARB_STRICT_PRIO_EN to give port 0 strict priority instead.
module spram_port_arbiter #(
   parameter int DATA_WIDTH = 72,
   parameter int ADDR_WIDTH = 7,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_done,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy
);

   localparam int TAG_DEPTH = RD_LATENCY + 1;

   localparam logic [0:0] ST_WAIT_INIT = 1'b0;
   localparam logic [0:0] ST_RUN       = 1'b1;

   logic [0:0]            state;
   logic                  last_grant;
   logic [TAG_DEPTH-1:0]  tag_valid;
   logic [TAG_DEPTH-1:0]  tag_port;
   logic                  grant_valid;
   logic                  grant_port;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  rsp_hit;

   // Grants stop in the same cycle init_done drops, not one cycle later.
   always_comb begin
      grant_valid = 1'b0;
      grant_port  = 1'b0;
      if ((state == ST_RUN) && init_done && !rst && (req0_valid || req1_valid)) begin
         grant_valid = 1'b1;
`ifdef SPRAM_ARB_STRICT_PRIO_EN
         grant_port = ~req0_valid;
`else
         if (req0_valid && req1_valid) begin
            grant_port = ~last_grant;
         end else begin
            grant_port = ~req0_valid;
         end
`endif
      end
   end

   assign req0_ready = grant_valid & ~grant_port;
   assign req1_ready = grant_valid & grant_port;

   assign sel_we    = grant_port ? req1_we    : req0_we;
   assign sel_addr  = grant_port ? req1_addr  : req0_addr;
   assign sel_wdata = grant_port ? req1_wdata : req0_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_WAIT_INIT;
         last_grant <= 1'b1;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         tag_valid  <= '0;
         tag_port   <= '0;
      end else begin
         case (state)
            ST_WAIT_INIT: if (init_done) state <= ST_RUN;
            default:      if (!init_done) state <= ST_WAIT_INIT;
         endcase
         ram_we <= grant_valid & sel_we;
         if (grant_valid) begin
            last_grant <= grant_port;
            ram_addr   <= sel_addr;
            ram_wdata  <= sel_wdata;
         end
         tag_valid <= {tag_valid[TAG_DEPTH-2:0], grant_valid & ~sel_we};
         tag_port  <= {tag_port[TAG_DEPTH-2:0], grant_port};
      end
   end

   // A reset cycle suppresses responses still sitting at the pipe output.
   assign rsp_hit    = tag_valid[RD_LATENCY] & ~rst;
   assign rsp0_valid = rsp_hit & ~tag_port[RD_LATENCY];
   assign rsp1_valid = rsp_hit & tag_port[RD_LATENCY];
   assign rsp0_rdata = rsp0_valid ? ram_rdata : '0;
   assign rsp1_rdata = rsp1_valid ? ram_rdata : '0;

   assign busy = (state == ST_WAIT_INIT) | (|tag_valid);

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Bench for spram_port_arbiter: RAM model plus a transaction-level reference model.
// Honours SPRAM_ARB_STRICT_PRIO_EN the same way the design does.
module tb_spram_port_arbiter;

   localparam int DW  = 72;
   localparam int AW  = 7;
   localparam int RDL = 2;

   logic          clk;
   logic          rst;
   logic          init_done;
   logic          req0_valid, req0_ready, req0_we, rsp0_valid;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, rsp0_rdata;
   logic          req1_valid, req1_ready, req1_we, rsp1_valid;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, rsp1_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic          busy;

   spram_port_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .RD_LATENCY(RDL)
   ) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int i);
      return DW'(i) * 72'h10_0001_0001 + 72'h5A;
   endfunction

   // RAM: registered address, RDL cycles from address to data.
   logic [DW-1:0] mem   [1 << AW];
   logic [DW-1:0] rpipe [4];
   initial for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(i);
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rpipe[0] <= mem[ram_addr];
      for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[RDL-1];

   // Reference model: arbitration rule, shadow memory, expected-response list.
   typedef struct {
      int            due;
      bit            port;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          pend [$];
   logic [DW-1:0] sh [1 << AW];
   bit            m_run, m_last;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   int            cyc, checks, errors, p1_grants;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      m_run   = 1'b0;
      m_last  = 1'b1;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
   endtask

   // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
   task automatic tick();
      bit            gv, gp, ev0, ev1;
      logic [DW-1:0] ed;
      #4;
      gv = 1'b0;
      gp = 1'b0;
      if (m_run && init_done && !rst && (req0_valid || req1_valid)) begin
         gv = 1'b1;
`ifdef SPRAM_ARB_STRICT_PRIO_EN
         gp = !req0_valid;
`else
         gp = (req0_valid && req1_valid) ? !m_last : !req0_valid;
`endif
      end
      ev0 = 1'b0;
      ev1 = 1'b0;
      ed  = '0;
      if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
         ev0 = !pend[0].port;
         ev1 = pend[0].port;
         ed  = pend[0].data;
      end
      if (req1_ready === 1'b1) p1_grants++;
      chk("req0_ready", DW'(req0_ready), DW'(gv && !gp));
      chk("req1_ready", DW'(req1_ready), DW'(gv && gp));
      chk("rsp0_valid", DW'(rsp0_valid), DW'(ev0));
      chk("rsp1_valid", DW'(rsp1_valid), DW'(ev1));
      chk("rsp0_rdata", rsp0_rdata, ev0 ? ed : '0);
      chk("rsp1_rdata", rsp1_rdata, ev1 ? ed : '0);
      if (!rst) begin
         chk("ram_we", DW'(ram_we), DW'(m_we));
         chk("ram_addr", DW'(ram_addr), DW'(m_addr));
         chk("ram_wdata", ram_wdata, m_wdata);
         chk("busy", DW'(busy), DW'(!m_run || pend.size() > 0));
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
         m_we = 1'b0;
         if (gv) begin
            m_last  = gp;
            m_we    = gp ? req1_we : req0_we;
            m_addr  = gp ? req1_addr : req0_addr;
            m_wdata = gp ? req1_wdata : req0_wdata;
            if (m_we) sh[m_addr] = m_wdata;
            else pend.push_back('{due: cyc + 1 + RDL, port: gp, data: sh[m_addr]});
         end
         m_run = init_done;
      end
      cyc++;
      #1;
   endtask

   task automatic drive(input bit v0, input bit w0, input int a0, input logic [DW-1:0] d0,
                        input bit v1, input bit w1, input int a1, input logic [DW-1:0] d1);
      req0_valid = v0;
      req0_we    = w0;
      req0_addr  = AW'(a0);
      req0_wdata = d0;
      req1_valid = v1;
      req1_we    = w1;
      req1_addr  = AW'(a1);
      req1_wdata = d1;
   endtask

   function automatic logic [DW-1:0] rnd72();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      p1_grants = 0;
      for (int i = 0; i < (1 << AW); i++) sh[i] = init_word(i);
      model_reset();
      rst       = 1'b1;
      init_done = 1'b0;
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Init hold with both ports requesting.
      drive(1, 0, 1, '0, 1, 0, 2, '0);
      repeat (130) tick();
      init_done = 1'b1;
      tick();
      tick();
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      repeat (4) tick();

      // Write then read on port 0.
      drive(1, 1, 5, 72'h12, 0, 0, 0, '0);
      tick();
      drive(1, 0, 5, '0, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      repeat (4) tick();

      // Round-robin read stream.
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 10 + i, '0, 1, 0, 40 + i, '0);
         tick();
      end
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      repeat (5) tick();

      // Write by port 1 then read of the same address by port 0.
      drive(0, 0, 0, '0, 1, 1, 9, 72'hAB);
      tick();
      drive(1, 0, 9, '0, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      repeat (4) tick();

      // init_done drops with two reads in flight.
      drive(1, 0, 20, '0, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, '0, 1, 0, 21, '0);
      tick();
      init_done = 1'b0;
      drive(1, 0, 22, '0, 1, 0, 23, '0);
      repeat (5) tick();
      init_done = 1'b1;
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      repeat (2) tick();

      // Reset with three reads in the pipe.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 30 + i, '0, 0, 0, 0, '0);
         tick();
      end
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (6) tick();

`ifdef SPRAM_ARB_STRICT_PRIO_EN
      p1_grants = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 50 + i, '0, 1, 0, 60 + i, '0);
         tick();
      end
      chk("strict_p1_grants", DW'(p1_grants), '0);
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      repeat (4) tick();
`endif

      // Random traffic over a small address window to exercise hazards.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 7), rnd72(),
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 7), rnd72());
         init_done = $urandom_range(0, 19) != 0;
         rst       = $urandom_range(0, 99) == 0;
         tick();
      end
      rst       = 1'b0;
      init_done = 1'b1;
      drive(0, 0, 0, '0, 0, 0, 0, '0);
      repeat (8) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
